// File: rtl/cam_ctrl_pkg.sv
// Shared types and constants for the camera capture sequencer: FSM encoding,
// debug status word layout and FPS output width.
package cam_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } cap_state_t;

    localparam int STATE_LSB  = 0;
    localparam int PEND_BIT   = 2;
    localparam int MISSED_BIT = 3;
    localparam int FCNT_LSB   = 16;
    localparam int FCNT_W     = 16;

    localparam int FPS_W = 32;

endpackage

// File: rtl/cam_capture_ctrl_fps_meter.sv
// Frame-rate meter: counts completed frames over a window of CLK_FREQ_HZ
// cycles and publishes the total at the end of each window.
module fps_meter
    import cam_ctrl_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             frame_done,
    output logic [FPS_W-1:0] frames_per_second
);

    localparam logic [31:0] WIN_LAST = 32'(CLK_FREQ_HZ - 1);

    logic [31:0]      win_cnt;
    logic [FPS_W-1:0] done_cnt;
    logic [FPS_W-1:0] done_inc;

    // A completion on the terminal cycle still belongs to the closing window.
    assign done_inc = done_cnt + FPS_W'(frame_done);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            win_cnt           <= '0;
            done_cnt          <= '0;
            frames_per_second <= '0;
        end else if (win_cnt == WIN_LAST) begin
            win_cnt           <= '0;
            done_cnt          <= '0;
            frames_per_second <= done_inc;
        end else begin
            win_cnt  <= win_cnt + 32'd1;
            done_cnt <= done_inc;
        end
    end

endmodule

// File: rtl/cam_capture_ctrl.sv
// Camera capture sequencer: arms on register requests, captures whole frames,
// waits for the DMA flush and reports status plus measured frame rate.
module cam_capture_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cam_confdone,
    input  logic        cam_dma_init_done,
    input  logic        trigger_capture_frame,
    input  logic        continuous_capture_frame,
    input  logic        frame_start,
    input  logic        frame_end,
    input  logic        dma_done,
    output logic        dma_start,
    output logic        capture_en,
    output logic        capture_busy,
    output logic [31:0] frames_per_second,
    output logic [31:0] cam_dma_status
);

    // Pulse semantics: frame_start, frame_end, dma_done and dma_start are
    // single-cycle strobes with no backpressure; each high cycle is one event.

    cap_state_t        state, state_next;
    logic              trig_q;
    logic              pend_single;
    logic              missed_end;
    logic              done_pend;
    logic [FCNT_W-1:0] frame_count;
    logic              ready;
    logic              trig_rise;
    logic              drain_exit;
    logic              pend_clear;

    assign ready      = cam_confdone & cam_dma_init_done;
    assign trig_rise  = trigger_capture_frame & ~trig_q;
    assign pend_clear = (state == IDLE) && (state_next == ARMED);

    always_comb begin
        state_next = state;
        drain_exit = 1'b0;
        case (state)
            IDLE: begin
                if (ready && (pend_single || continuous_capture_frame))
                    state_next = ARMED;
            end
            ARMED: begin
                if (!ready)
                    state_next = IDLE;
                else if (frame_start)
                    state_next = CAPTURE;
            end
            CAPTURE: begin
                if (frame_end)
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (dma_done || done_pend) begin
                    drain_exit = 1'b1;
                    state_next = (continuous_capture_frame && ready) ? ARMED : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            trig_q       <= 1'b0;
            pend_single  <= 1'b0;
            missed_end   <= 1'b0;
            done_pend    <= 1'b0;
            frame_count  <= '0;
            dma_start    <= 1'b0;
            capture_en   <= 1'b0;
            capture_busy <= 1'b0;
        end else begin
            state  <= state_next;
            trig_q <= trigger_capture_frame;

            // Only one single-shot request is held; extra edges are absorbed.
            if (pend_single) begin
                if (pend_clear)
                    pend_single <= 1'b0;
            end else if (trig_rise) begin
                pend_single <= 1'b1;
            end

            if (!cam_confdone)
                missed_end <= 1'b0;
            else if (state == CAPTURE && frame_start)
                missed_end <= 1'b1;

            if (drain_exit)
                done_pend <= 1'b0;
            else if (state == CAPTURE && dma_done)
                done_pend <= 1'b1;

            frame_count  <= frame_count + FCNT_W'(drain_exit);
            dma_start    <= (state == ARMED) && (state_next == CAPTURE);
            capture_en   <= (state_next == CAPTURE);
            capture_busy <= (state_next != IDLE);
        end
    end

    always_comb begin
        cam_dma_status                        = '0;
        cam_dma_status[STATE_LSB +: 2]        = state;
        cam_dma_status[PEND_BIT]              = pend_single;
        cam_dma_status[MISSED_BIT]            = missed_end;
        cam_dma_status[FCNT_LSB +: FCNT_W]    = frame_count;
    end

    fps_meter #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_fps_meter (
        .clk              (clk),
        .resetn           (resetn),
        .frame_done       (drain_exit),
        .frames_per_second(frames_per_second)
    );

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Self-checking bench for cam_capture_ctrl: randomized frame timing checked
// against a frame-level model (completion times, window totals, counts).
`timescale 1ns/1ps
module tb_cam_capture_ctrl;

    localparam int WIN = 1000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cam_confdone = 1'b0;
    logic        cam_dma_init_done = 1'b0;
    logic        trigger_capture_frame = 1'b0;
    logic        continuous_capture_frame = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_end = 1'b0;
    logic        dma_done = 1'b0;
    logic        dma_start;
    logic        capture_en;
    logic        capture_busy;
    logic [31:0] frames_per_second;
    logic [31:0] cam_dma_status;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc;
    int n_start;
    int n_cap;
    int start_edge;
    logic [15:0] exp_fcnt;
    int comp_q[$];

    logic [1:0]  st;
    logic        pend;
    logic        missed;
    logic [15:0] fcnt;
    assign st     = cam_dma_status[1:0];
    assign pend   = cam_dma_status[2];
    assign missed = cam_dma_status[3];
    assign fcnt   = cam_dma_status[31:16];

    cam_capture_ctrl #(
        .CLK_FREQ_HZ(WIN)
    ) dut (
        .clk                     (clk),
        .resetn                  (resetn),
        .cam_confdone            (cam_confdone),
        .cam_dma_init_done       (cam_dma_init_done),
        .trigger_capture_frame   (trigger_capture_frame),
        .continuous_capture_frame(continuous_capture_frame),
        .frame_start             (frame_start),
        .frame_end               (frame_end),
        .dma_done                (dma_done),
        .dma_start               (dma_start),
        .capture_en              (capture_en),
        .capture_busy            (capture_busy),
        .frames_per_second       (frames_per_second),
        .cam_dma_status          (cam_dma_status)
    );

    // clock / reset / timeline
    always #5 clk = ~clk;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (resetn) begin
            if (dma_start) begin
                n_start    = n_start + 1;
                start_edge = cyc;
            end
            if (capture_en) n_cap = n_cap + 1;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_start    = 0;
        n_cap      = 0;
        start_edge = -1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        trigger_capture_frame = 1'b0;
        continuous_capture_frame = 1'b0;
        frame_start = 1'b0;
        frame_end = 1'b0;
        dma_done = 1'b0;
        cam_confdone = 1'b1;
        cam_dma_init_done = 1'b1;
        exp_fcnt = '0;
        comp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        clear_mon();
    endtask

    task automatic arm_single();
        trigger_capture_frame = 1'b1;
        tick();
        tick();
        trigger_capture_frame = 1'b0;
    endtask

    // Frame of len cycles; dma_done dly cycles after frame_end (0 = same cycle).
    // A frame completes at the later of (frame_end edge + 1, dma_done edge).
    task automatic run_frame(input int len, input int dly, input int clr_at,
                             output int s_edge, output int c_edge);
        frame_start = 1'b1;
        tick();
        s_edge = cyc;
        frame_start = 1'b0;
        for (int i = 0; i < len - 1; i++) begin
            if (i == clr_at) continuous_capture_frame = 1'b0;
            tick();
        end
        frame_end = 1'b1;
        if (dly == 0) dma_done = 1'b1;
        tick();
        frame_end = 1'b0;
        dma_done = 1'b0;
        if (dly > 0) begin
            repeat (dly - 1) tick();
            dma_done = 1'b1;
            tick();
            dma_done = 1'b0;
            c_edge = cyc;
        end else begin
            c_edge = cyc + 1;
        end
    endtask

    function automatic int count_in(input int lo, input int hi);
        int n = 0;
        foreach (comp_q[i]) if (comp_q[i] >= lo && comp_q[i] <= hi) n++;
        return n;
    endfunction

    // scenarios
    task automatic test_reset();
        apply_reset();
        n_tests++; if (dma_start !== 1'b0) begin n_fail++; $display("FAIL reset_dma_start: got %b want 0", dma_start); end
        n_tests++; if (capture_en !== 1'b0) begin n_fail++; $display("FAIL reset_capture_en: got %b want 0", capture_en); end
        n_tests++; if (capture_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", capture_busy); end
        n_tests++; if (frames_per_second !== 32'd0) begin n_fail++; $display("FAIL reset_fps: got %0d want 0", frames_per_second); end
        n_tests++; if (cam_dma_status !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h want 0", cam_dma_status); end
    endtask

    task automatic test_single_shot();
        int len, dly, s_e, c_e;
        for (int it = 0; it < 3; it++) begin
            len = (it == 0) ? 100 : int'($urandom_range(20, 120));
            dly = (it == 0) ? 20 : int'($urandom_range(1, 30));
            clear_mon();
            arm_single();
            n_tests++; if (st !== 2'd1) begin n_fail++; $display("FAIL single_armed: got %0d want 1", st); end
            repeat ($urandom_range(1, 5)) tick();
            run_frame(len, dly, -1, s_e, c_e);
            exp_fcnt++;
            n_tests++; if (n_start !== 1) begin n_fail++; $display("FAIL single_start_count: got %0d want 1", n_start); end
            n_tests++; if (start_edge !== s_e) begin n_fail++; $display("FAIL single_start_time: got %0d want %0d", start_edge, s_e); end
            n_tests++; if (n_cap !== len) begin n_fail++; $display("FAIL single_capture_len: got %0d want %0d", n_cap, len); end
            n_tests++; if (fcnt !== exp_fcnt) begin n_fail++; $display("FAIL single_fcnt: got %0d want %0d", fcnt, exp_fcnt); end
            n_tests++; if (st !== 2'd0 || capture_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got st=%0d busy=%b want st=0 busy=0", st, capture_busy); end
            tick();
        end
    endtask

    task automatic test_early_dma();
        int s_e, c_e;
        clear_mon();
        arm_single();
        tick();
        run_frame(int'($urandom_range(20, 60)), 0, -1, s_e, c_e);
        n_tests++; if (st !== 2'd3) begin n_fail++; $display("FAIL early_drain: got %0d want 3", st); end
        tick();
        exp_fcnt++;
        n_tests++; if (st !== 2'd0) begin n_fail++; $display("FAIL early_exit: got %0d want 0", st); end
        n_tests++; if (fcnt !== exp_fcnt) begin n_fail++; $display("FAIL early_fcnt: got %0d want %0d", fcnt, exp_fcnt); end
        repeat (3) tick();
        n_tests++; if (fcnt !== exp_fcnt) begin n_fail++; $display("FAIL early_fcnt_once: got %0d want %0d", fcnt, exp_fcnt); end
    endtask

    task automatic test_not_ready();
        int s_e, c_e;
        clear_mon();
        cam_dma_init_done = 1'b0;
        arm_single();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        n_tests++; if (n_start !== 0) begin n_fail++; $display("FAIL notready_start: got %0d want 0", n_start); end
        n_tests++; if (st !== 2'd0) begin n_fail++; $display("FAIL notready_state: got %0d want 0", st); end
        n_tests++; if (pend !== 1'b1) begin n_fail++; $display("FAIL notready_pend: got %b want 1", pend); end
        trigger_capture_frame = 1'b1;
        tick();
        trigger_capture_frame = 1'b0;
        tick();
        cam_dma_init_done = 1'b1;
        tick();
        n_tests++; if (st !== 2'd1 || pend !== 1'b0) begin n_fail++; $display("FAIL notready_arm: got st=%0d pend=%b want st=1 pend=0", st, pend); end
        run_frame(30, 2, -1, s_e, c_e);
        exp_fcnt++;
        repeat (5) tick();
        n_tests++; if (st !== 2'd0 || fcnt !== exp_fcnt) begin n_fail++; $display("FAIL notready_absorb: got st=%0d fcnt=%0d want st=0 fcnt=%0d", st, fcnt, exp_fcnt); end
        arm_single();
        cam_dma_init_done = 1'b0;
        tick();
        n_tests++; if (st !== 2'd0) begin n_fail++; $display("FAIL notready_disarm: got %0d want 0", st); end
        cam_dma_init_done = 1'b1;
        tick();
    endtask

    task automatic test_missed_end();
        clear_mon();
        arm_single();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (20) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n_tests++; if (missed !== 1'b1) begin n_fail++; $display("FAIL missed_set: got %b want 1", missed); end
        n_tests++; if (st !== 2'd2) begin n_fail++; $display("FAIL missed_stay: got %0d want 2", st); end
        repeat (10) tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        exp_fcnt++;
        n_tests++; if (n_start !== 1) begin n_fail++; $display("FAIL missed_one_start: got %0d want 1", n_start); end
        n_tests++; if (missed !== 1'b1 || fcnt !== exp_fcnt) begin n_fail++; $display("FAIL missed_sticky: got m=%b fcnt=%0d want m=1 fcnt=%0d", missed, fcnt, exp_fcnt); end
        cam_confdone = 1'b0;
        tick();
        n_tests++; if (missed !== 1'b0) begin n_fail++; $display("FAIL missed_clear: got %b want 0", missed); end
        cam_confdone = 1'b1;
        tick();
    endtask

    task automatic test_continuous_fps();
        int len, dly, s_e, c_e;
        apply_reset();
        continuous_capture_frame = 1'b1;
        tick();
        for (int f = 0; f < 5; f++) begin
            repeat ($urandom_range(2, 8)) tick();
            len = int'($urandom_range(110, 140));
            dly = int'($urandom_range(0, 10));
            run_frame(len, dly, -1, s_e, c_e);
            comp_q.push_back(c_e);
            exp_fcnt++;
        end
        tick();
        n_tests++; if (fcnt !== exp_fcnt || st !== 2'd1) begin n_fail++; $display("FAIL cont_five: got fcnt=%0d st=%0d want fcnt=%0d st=1", fcnt, st, exp_fcnt); end
        while (cyc < WIN) tick();
        n_tests++; if (frames_per_second !== 32'(count_in(1, WIN))) begin n_fail++; $display("FAIL fps_window1: got %0d want %0d", frames_per_second, count_in(1, WIN)); end
        tick();
        len = int'($urandom_range(110, 140));
        run_frame(len, int'($urandom_range(1, 10)), 50, s_e, c_e);
        comp_q.push_back(c_e);
        exp_fcnt++;
        tick();
        n_tests++; if (fcnt !== exp_fcnt) begin n_fail++; $display("FAIL cont_frame6: got %0d want %0d", fcnt, exp_fcnt); end
        n_tests++; if (st !== 2'd0 || capture_busy !== 1'b0) begin n_fail++; $display("FAIL cont_stop: got st=%0d busy=%b want st=0 busy=0", st, capture_busy); end
        while (cyc < 2 * WIN) tick();
        n_tests++; if (frames_per_second !== 32'(count_in(WIN + 1, 2 * WIN))) begin n_fail++; $display("FAIL fps_window2: got %0d want %0d", frames_per_second, count_in(WIN + 1, 2 * WIN)); end
    endtask

    task automatic test_reset_mid_capture();
        clear_mon();
        arm_single();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (30) tick();
        n_tests++; if (capture_en !== 1'b1) begin n_fail++; $display("FAIL rst_pre_capture: got %b want 1", capture_en); end
        #2;
        resetn = 1'b0;
        #1;
        n_tests++; if (capture_en !== 1'b0 || capture_busy !== 1'b0 || dma_start !== 1'b0) begin n_fail++; $display("FAIL rst_async_ctrl: got en=%b busy=%b start=%b want 0", capture_en, capture_busy, dma_start); end
        n_tests++; if (frames_per_second !== 32'd0 || cam_dma_status !== 32'd0) begin n_fail++; $display("FAIL rst_async_regs: got fps=%0d status=%h want 0", frames_per_second, cam_dma_status); end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        exp_fcnt = '0;
        clear_mon();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (5) tick();
        n_tests++; if (n_start !== 0 || st !== 2'd0 || fcnt !== exp_fcnt) begin n_fail++; $display("FAIL rst_after: got starts=%0d st=%0d fcnt=%0d want 0 0 0", n_start, st, fcnt); end
    endtask

    // final report
    initial begin
        test_reset();
        test_single_shot();
        test_early_dma();
        test_not_ready();
        test_missed_end();
        test_continuous_fps();
        test_reset_mid_capture();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
